ordered_event_ctrl: RTL and testbench

Programmable time-ordered event detector and controller. It generalises our fixed "a, then a&b, then a&b&c" detectors into a runtime-configured sequence of up to MAX_STEPS cumulative event masks. Software or a host FSM loads the masks, arms the block, then reads the saturating hit counter. It sits between the raw event sources and the interrupt/status logic.

---
 rtl/ordered_event_ctrl.sv | 145 ++++++++++++++
 tb/tb_ordered_event_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ordered_event_ctrl.sv
// Programmable time-ordered event detector: walks a runtime-loaded sequence of cumulative masks
// and counts completed sequences. Define ORDERED_EVENT_TIMEOUT_EN for the per-step timeout.
module ordered_event_ctrl #(
    parameter int unsigned N_IN      = 3,
    parameter int unsigned MAX_STEPS = 4,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned TMO_W     = 8,
    localparam int unsigned IDX_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  ev,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [N_IN-1:0]  cfg_mask,
    input  logic             cfg_len_we,
    input  logic [IDX_W:0]   cfg_len,
    input  logic             arm,
    input  logic             disarm,
`ifdef ORDERED_EVENT_TIMEOUT_EN
    input  logic [TMO_W-1:0] cfg_tmo,
    output logic             tmo,
`endif
    output logic             busy,
    output logic [IDX_W-1:0] step,
    output logic             hit,
    output logic [CNT_W-1:0] hit_cnt,
    output logic             cfg_err
);

    if (N_IN < 1 || MAX_STEPS < 1 || CNT_W < 1 || TMO_W < 1) begin : g_bad_params
        $error("ordered_event_ctrl: all parameters must be at least 1");
    end

    localparam logic [IDX_W:0] MAX_LEN = (IDX_W+1)'(MAX_STEPS);

    typedef enum logic [1:0] {StIdle, StRun, StMatch} state_e;

    state_e          state;
    logic [N_IN-1:0] mask [MAX_STEPS];
    logic [IDX_W:0]  len;

    logic [IDX_W-1:0] prev_idx;
    logic             cover_cur;
    logic             cover_prev;
    logic             last_step;
    logic             idx_ok;
    logic             len_ok;
    logic             cfg_bad;

`ifdef ORDERED_EVENT_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_fire;
`endif

    always_comb begin
        prev_idx   = step - IDX_W'(1);
        cover_cur  = (ev & mask[step]) == mask[step];
        // Step 0 has no predecessor, so the hold condition is trivially met there.
        cover_prev = (step == '0) || ((ev & mask[prev_idx]) == mask[prev_idx]);
        last_step  = (IDX_W+1)'(step) + (IDX_W+1)'(1) == len;
        idx_ok     = 32'(cfg_idx) < MAX_STEPS;
        len_ok     = (cfg_len != '0) && (cfg_len <= MAX_LEN);
        cfg_bad    = (cfg_we && (state != StIdle || !idx_ok)) ||
                     (cfg_len_we && (state != StIdle || !len_ok));
`ifdef ORDERED_EVENT_TIMEOUT_EN
        tmo_fire   = (cfg_tmo != '0) && (step != '0) && (tmo_cnt == cfg_tmo);
`endif
    end

    assign busy = (state != StIdle);
    assign hit  = (state == StMatch);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= StIdle;
            step    <= '0;
            hit_cnt <= '0;
            cfg_err <= 1'b0;
            len     <= (IDX_W+1)'(1);
            for (int i = 0; i < int'(MAX_STEPS); i++) begin
                mask[i] <= '0;
            end
`ifdef ORDERED_EVENT_TIMEOUT_EN
            tmo     <= 1'b0;
            tmo_cnt <= '0;
`endif
        end else begin
            cfg_err <= cfg_bad;
            if (cfg_we && state == StIdle && idx_ok) begin
                mask[cfg_idx] <= cfg_mask;
            end
            if (cfg_len_we && state == StIdle && len_ok) begin
                len <= cfg_len;
            end
`ifdef ORDERED_EVENT_TIMEOUT_EN
            tmo     <= 1'b0;
            tmo_cnt <= '0;
`endif
            if (disarm) begin
                state <= StIdle;
                step  <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (arm) begin
                            state   <= StRun;
                            step    <= '0;
                            hit_cnt <= '0;
                        end
                    end
                    StMatch: begin
                        state <= StRun;
                        step  <= '0;
                        if (hit_cnt != '1) begin
                            hit_cnt <= hit_cnt + CNT_W'(1);
                        end
                    end
                    StRun: begin
                        if (!cover_prev) begin
                            step <= '0;
                        end else if (cover_cur && last_step) begin
                            state <= StMatch;
                            step  <= '0;
                        end else if (cover_cur) begin
                            step <= step + IDX_W'(1);
`ifdef ORDERED_EVENT_TIMEOUT_EN
                        end else if (tmo_fire) begin
                            step <= '0;
                            tmo  <= 1'b1;
                        end else if (step != '0) begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
                        end
                    end
                    default: begin
                        state <= StIdle;
                        step  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ordered_event_ctrl.sv
// Self-checking bench for ordered_event_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural sequence model.
module tb_ordered_event_ctrl;

    localparam int N_IN      = 3;
    localparam int MAX_STEPS = 4;
    localparam int CNT_W     = 2;
    localparam int TMO_W     = 8;
    localparam int IDX_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [N_IN-1:0]  ev;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [N_IN-1:0]  cfg_mask;
    logic             cfg_len_we;
    logic [IDX_W:0]   cfg_len;
    logic             arm;
    logic             disarm;
    logic             busy;
    logic [IDX_W-1:0] step;
    logic             hit;
    logic [CNT_W-1:0] hit_cnt;
    logic             cfg_err;
`ifdef ORDERED_EVENT_TIMEOUT_EN
    logic [TMO_W-1:0] cfg_tmo;
    logic             tmo;
`endif

    ordered_event_ctrl #(
        .N_IN      (N_IN),
        .MAX_STEPS (MAX_STEPS),
        .CNT_W     (CNT_W),
        .TMO_W     (TMO_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ev         (ev),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_mask   (cfg_mask),
        .cfg_len_we (cfg_len_we),
        .cfg_len    (cfg_len),
        .arm        (arm),
        .disarm     (disarm),
`ifdef ORDERED_EVENT_TIMEOUT_EN
        .cfg_tmo    (cfg_tmo),
        .tmo        (tmo),
`endif
        .busy       (busy),
        .step       (step),
        .hit        (hit),
        .hit_cnt    (hit_cnt),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 = idle, 1 = running, 2 = match cycle.
    int m_st;
    int m_step;
    int m_cnt;
    int m_len;
    int m_wait;
    int m_mask [MAX_STEPS];
    bit m_err;
    bit m_tmo;

    function automatic bit covers(input int m);
        return ((int'(ev) & m) == m);
    endfunction

    task automatic model_reset();
        m_st = 0; m_step = 0; m_cnt = 0; m_len = 1; m_wait = 0; m_err = 0; m_tmo = 0;
        for (int i = 0; i < MAX_STEPS; i++) m_mask[i] = 0;
    endtask

    task automatic model_update();
        bit err;
        bit was_idle;
        err = 1'b0;
        was_idle = (m_st == 0);
        m_tmo = 1'b0;
        if (cfg_we) begin
            if (was_idle && int'(cfg_idx) < MAX_STEPS) m_mask[cfg_idx] = int'(cfg_mask);
            else err = 1'b1;
        end
        if (cfg_len_we) begin
            if (was_idle && int'(cfg_len) >= 1 && int'(cfg_len) <= MAX_STEPS) m_len = int'(cfg_len);
            else err = 1'b1;
        end
        if (disarm) begin
            m_st = 0; m_step = 0; m_wait = 0;
        end else if (m_st == 0) begin
            if (arm) begin m_st = 1; m_step = 0; m_cnt = 0; end
            m_wait = 0;
        end else if (m_st == 2) begin
            if (m_cnt < CNT_MAX) m_cnt++;
            m_st = 1; m_step = 0; m_wait = 0;
        end else begin
            if (m_step > 0 && !covers(m_mask[m_step-1])) begin
                m_step = 0; m_wait = 0;
            end else if (covers(m_mask[m_step])) begin
                m_wait = 0;
                if (m_step == m_len - 1) begin m_st = 2; m_step = 0; end
                else m_step++;
            end else begin
`ifdef ORDERED_EVENT_TIMEOUT_EN
                if (m_step > 0 && cfg_tmo != 0 && m_wait == int'(cfg_tmo)) begin
                    m_step = 0; m_wait = 0; m_tmo = 1'b1;
                end else if (m_step > 0) begin
                    m_wait++;
                end
`endif
            end
        end
        m_err = err;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_update();
    end

    always @(negedge clk) begin
        if (reset) begin
            check("m_busy", busy, m_st != 0);
            check("m_step", step, m_step);
            check("m_hit", hit, m_st == 2);
            check("m_hit_cnt", hit_cnt, m_cnt);
            check("m_cfg_err", cfg_err, m_err);
`ifdef ORDERED_EVENT_TIMEOUT_EN
            check("m_tmo", tmo, m_tmo);
`endif
        end
    end

    task automatic clear_inputs();
        ev = '0; cfg_we = 0; cfg_idx = '0; cfg_mask = '0; cfg_len_we = 0; cfg_len = '0;
        arm = 0; disarm = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load_std();
        logic [N_IN-1:0] vals [3];
        vals[0] = 3'b001; vals[1] = 3'b011; vals[2] = 3'b111;
        for (int i = 0; i < 3; i++) begin
            cfg_we = 1; cfg_idx = IDX_W'(i); cfg_mask = vals[i]; cyc();
        end
        cfg_we = 0; cfg_len_we = 1; cfg_len = 3'd3; cyc();
        cfg_len_we = 0; cyc();
        check("cfg_ok", cfg_err, 0);
    endtask

    task automatic do_disarm();
        disarm = 1; cyc(); disarm = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        bit seen;
        model_reset();
        clear_inputs();
`ifdef ORDERED_EVENT_TIMEOUT_EN
        cfg_tmo = '0;
`endif
        repeat (3) cyc();
        check("rst_busy", busy, 0);
        check("rst_step", step, 0);
        check("rst_hit", hit, 0);
        check("rst_cnt", hit_cnt, 0);
        check("rst_err", cfg_err, 0);
        reset = 1;
        cyc();
        load_std();

        // Basic match.
        arm = 1; cyc(); arm = 0;
        check("basic_busy", busy, 1);
        check("basic_s0", step, 0);
        ev = 3'b001; cyc(); check("basic_s1", step, 1);
        ev = 3'b011; cyc(); check("basic_s2", step, 2);
        ev = 3'b111; cyc(); check("basic_hit", hit, 1); check("basic_mstep", step, 0);
        ev = 3'b000; cyc(); check("basic_hit_lo", hit, 0); check("basic_cnt", hit_cnt, 1);
        check("basic_back0", step, 0);
        do_disarm(); cyc(); check("disarm_idle", busy, 0);

        // Hold lost.
        arm = 1; cyc(); arm = 0;
        ev = 3'b011; cyc(); check("hold_s1", step, 1);
        ev = 3'b011; cyc(); check("hold_s2", step, 2);
        ev = 3'b000; cyc(); check("hold_lost", step, 0); check("hold_nohit", hit, 0);
        ev = 3'b111; cyc(); ev = 3'b000;
        do_disarm();

        // Simultaneous and illegal commands.
        arm = 1; disarm = 1; cyc(); arm = 0; disarm = 0;
        check("armdis_idle", busy, 0);
        arm = 1; cyc(); arm = 0;
        cfg_we = 1; cfg_idx = 2'd1; cfg_mask = 3'b000; cyc(); cfg_we = 0;
        check("run_we_err", cfg_err, 1);
        cyc(); check("err_pulse_end", cfg_err, 0);
        do_disarm();
        cfg_len_we = 1; cfg_len = 3'd5; cyc();
        check("len5_err", cfg_err, 1);
        cfg_len = 3'd0; cyc(); cfg_len_we = 0;
        check("len0_err", cfg_err, 1);
        cyc(); check("len_err_end", cfg_err, 0);
        arm = 1; cyc(); arm = 0;
        ev = 3'b001; cyc(); check("kept_s1", step, 1);
        ev = 3'b001; cyc(); check("mask_kept", step, 1);
        ev = 3'b011; cyc(); check("kept_s2", step, 2);
        ev = 3'b111; disarm = 1; cyc(); disarm = 0; ev = 3'b000;
        check("dis_s2_idle", busy, 0); check("dis_s2_nohit", hit, 0); check("dis_s2_step", step, 0);

        // Saturation with ev held at 111.
        ev = 3'b111; arm = 1; cyc(); arm = 0;
        hits = 0;
        for (int i = 0; i <= 20; i++) begin
            cyc();
            if (hit) hits++;
            check("sat_hit", hit, (i % 4) == 2);
            check("sat_cnt", hit_cnt, ((i + 1) / 4 > 3) ? 3 : (i + 1) / 4);
        end
        check("sat_hits", hits, 5);
        ev = 3'b000; do_disarm();
        arm = 1; cyc(); arm = 0;
        check("rearm_clr", hit_cnt, 0);
        do_disarm();

`ifdef ORDERED_EVENT_TIMEOUT_EN
        // Timeout at step 1 with ev held at 001.
        cfg_tmo = 8'd4; ev = 3'b001; arm = 1; cyc(); arm = 0;
        for (int i = 0; i <= 6; i++) begin
            cyc();
            check("tmo_pulse", tmo, i == 5);
            check("tmo_step", step, (i == 5) ? 0 : 1);
        end
        cfg_tmo = 8'd0; hits = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (tmo) hits++;
        end
        check("tmo_off", hits, 0);
        ev = 3'b000; do_disarm();
`endif

        // Reset during MATCH with a nonzero count.
        ev = 3'b111; arm = 1; cyc(); arm = 0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            if (hit && hit_cnt == 1) seen = 1;
        end
        check("rst_saw_match", seen, 1);
        #2 reset = 0;
        #1;
        check("arst_hit", hit, 0);
        check("arst_busy", busy, 0);
        check("arst_step", step, 0);
        check("arst_cnt", hit_cnt, 0);
        cyc(); cyc(); reset = 1;
        cyc(); check("post_rst_idle", busy, 0);
        // Masks back to zero and len 1: every RUN cycle completes the sequence.
        arm = 1; cyc(); arm = 0;
        check("post_rst_run", busy, 1);
        cyc(); check("post_rst_hit", hit, 1);
        do_disarm();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            arm        = ($urandom_range(0, 99) < 6);
            disarm     = ($urandom_range(0, 99) < 3);
            cfg_we     = ($urandom_range(0, 99) < 5);
            cfg_idx    = IDX_W'($urandom_range(0, 3));
            cfg_mask   = N_IN'($urandom_range(0, 7));
            cfg_len_we = ($urandom_range(0, 99) < 3);
            cfg_len    = 3'($urandom_range(0, 7));
            ev         = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
`ifdef ORDERED_EVENT_TIMEOUT_EN
            if ($urandom_range(0, 99) < 2) cfg_tmo = 8'($urandom_range(0, 6));
`endif
            cyc();
        end
        clear_inputs();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
